// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box table, xtime, key-size constants and the word-slice macro
// used by the 128/192/256 key schedulers.
`ifndef AES_PKG_SV
`define AES_PKG_SV

// Word n (0 = leftmost, big-endian) of a packed vector that is `bits` wide.
`define AES_WORD(vec, bits, n) vec[(bits) - 1 - 32 * (n) -: 32]

package aes_pkg;

  localparam int unsigned NK_128 = 4;
  localparam int unsigned NK_192 = 6;
  localparam int unsigned NK_256 = 8;
  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDone} ks_state_e;

  // Byte x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = {~b, 3'b111};
    return SBOX_TABLE[pos -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`endif

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = sbox(word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes192_key_scheduler.sv
// Iterative AES-192 key expansion: one word per cycle into a 52-word store, then a
// registered 128-bit round-key read port.
module aes192_key_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned NK     = 6,
  parameter int unsigned NWORDS = 52
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         ready,
  output logic         done,
  input  logic         rd_en,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         rd_valid,
  output logic         rd_err
);

  ks_state_e    state_q;
  logic [31:0]  words_q [NWORDS];
  logic [5:0]   idx_q;
  logic [2:0]   phase_q;
  logic [7:0]   rcon_q;
  logic         busy_q, ready_q, done_q;
  logic [127:0] rd_key_q;
  logic         rd_valid_q, rd_err_q;

  logic         accept, writing, rd_ok;
  logic [31:0]  prev_word, back_word, sub_word, new_word;
  logic [5:0]   rd_base;

  assign accept  = start && (state_q == StIdle || state_q == StDone);
  assign writing = (state_q == StLoad || state_q == StExpand);

  assign prev_word = words_q[6'(idx_q - 6'd1)];
  assign back_word = words_q[6'(idx_q - 6'(NK))];

  aes_subword u_subword (
    .word   ({prev_word[23:0], prev_word[31:24]}),
    .result (sub_word)
  );

  assign new_word = back_word ^ ((phase_q == 3'd0) ? (sub_word ^ {rcon_q, 24'h0}) : prev_word);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      phase_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            idx_q   <= 6'(NK);
            phase_q <= '0;
            rcon_q  <= 8'h01;
          end else begin
            state_q <= StIdle;
          end
        end
        StLoad, StExpand: begin
          idx_q   <= idx_q + 6'd1;
          phase_q <= (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
          // Hold rcon at 80 after its last use so it never leaves 01..80.
          if (phase_q == 3'd0 && rcon_q != 8'h80) rcon_q <= xtime(rcon_q);
          if (idx_q == 6'(NWORDS - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= StExpand;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Word store is never cleared; ready guards its contents.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      words_q[0] <= `AES_WORD(key_in, 192, 0);
      words_q[1] <= `AES_WORD(key_in, 192, 1);
      words_q[2] <= `AES_WORD(key_in, 192, 2);
      words_q[3] <= `AES_WORD(key_in, 192, 3);
      words_q[4] <= `AES_WORD(key_in, 192, 4);
      words_q[5] <= `AES_WORD(key_in, 192, 5);
    end else if (!reset && writing) begin
      words_q[idx_q] <= new_word;
    end
  end

  assign rd_ok   = rd_en && ready_q && (rd_round <= 4'd12);
  assign rd_base = {rd_round, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      rd_err_q   <= rd_en && !rd_ok;
      if (rd_ok) begin
        rd_key_q <= {words_q[rd_base], words_q[rd_base | 6'd1],
                     words_q[rd_base | 6'd2], words_q[rd_base | 6'd3]};
      end
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign done     = done_q;
  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes192_key_scheduler.sv
// Scoreboard bench for aes192_key_scheduler: FIPS-197 vectors plus a reference expansion
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes192_key_scheduler;

  logic         clk = 1'b0;
  logic         reset, start, rd_en;
  logic [191:0] key_in;
  logic [3:0]   rd_round;
  logic         busy, ready, done, rd_valid, rd_err;
  logic [127:0] rd_key;

  aes192_key_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .ready    (ready),
    .done     (done),
    .rd_en    (rd_en),
    .rd_round (rd_round),
    .rd_key   (rd_key),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    logic         err;
    logic [127:0] key;
  } exp_t;

  localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  exp_t         exp_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           edges = 0;
  logic [7:0]   sbox_m [256];
  logic [31:0]  mw [52];
  logic         model_ready = 1'b0;
  logic [127:0] last_key = '0;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] s;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [191:0] k);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 6; i++) mw[i] = k[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = mw[i-1];
      if (i % 6 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      mw[i] = mw[i-6] ^ t;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic push_read(input int r);
    exp_t e;
    if (model_ready && r <= 12) begin
      e.valid = 1'b1;
      e.err   = 1'b0;
      e.key   = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      last_key = e.key;
    end else begin
      e.valid = 1'b0;
      e.err   = 1'b1;
      e.key   = last_key;
    end
    exp_q.push_back(e);
  endtask

  task automatic check_read(input string name);
    exp_t e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    if ({rd_valid, rd_err, rd_key} !== {e.valid, e.err, e.key}) begin
      tests_failed++;
      $display("FAIL %s: got valid=%b err=%b key=%h want valid=%b err=%b key=%h",
               name, rd_valid, rd_err, rd_key, e.valid, e.err, e.key);
    end
  endtask

  // Back-to-back reads, rd_en held high across consecutive edges.
  task automatic read_rounds(input string name, input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      rd_en = 1'b1;
      rd_round = 4'(r);
      push_read(r);
      step();
      check_read(name);
    end
    rd_en = 1'b0;
  endtask

  task automatic read_const(input string name, input int r, input logic [127:0] want);
    rd_en = 1'b1;
    rd_round = 4'(r);
    push_read(r);
    step();
    rd_en = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_key !== want) begin
      tests_failed++;
      $display("FAIL %s: got valid=%b key=%h want valid=1 key=%h", name, rd_valid, rd_key, want);
    end
    check_read({name, "_sb"});
  endtask

  task automatic start_expand(input logic [191:0] k);
    start = 1'b1;
    key_in = k;
    edges = 0;
    step();
    start = 1'b0;
    model_ready = 1'b0;
    model_expand(k);
    tests_run++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept: got busy=%b ready=%b want busy=1 ready=0", busy, ready);
    end
  endtask

  task automatic wait_done(input string name);
    while (done !== 1'b1 && edges < 100) step();
    tests_run++;
    if (done !== 1'b1 || edges != 47) begin
      tests_failed++;
      $display("FAIL %s_latency: got done=%b after %0d edges want done=1 after 47",
               name, done, edges);
    end
    step();
    model_ready = 1'b1;
    tests_run++;
    if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_after_done: got done=%b ready=%b busy=%b want 0 1 0",
               name, done, ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    rd_en = 1'b0;
    rd_round = '0;
    key_in = '0;
    step();
    step();
    reset = 1'b0;
    tests_run++;
    if ({busy, ready, done, rd_valid, rd_err} !== 5'b0 || rd_key !== '0) begin
      tests_failed++;
      $display("FAIL reset: got busy=%b ready=%b done=%b valid=%b err=%b key=%h want all 0",
               busy, ready, done, rd_valid, rd_err, rd_key);
    end
    last_key = '0;
    model_ready = 1'b0;
  endtask

  task automatic test_fips();
    start_expand(FIPS_KEY);
    wait_done("fips");
    read_const("fips_round0", 0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_const("fips_w6_w7", 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    read_const("fips_round12", 12, 128'he98ba06f448c773c8ecc720401002202);
    read_rounds("fips_all", 0, 12);
  endtask

  task automatic test_errors();
    read_rounds("err_round13", 13, 13);
    read_rounds("err_round15", 15, 15);
    tests_run++;
    step();
    if (rd_valid !== 1'b0 || rd_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_port: got valid=%b err=%b want 0 0", rd_valid, rd_err);
    end
    start_expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    read_rounds("err_busy", 0, 0);
    read_rounds("err_busy", 12, 12);
    wait_done("err");
    read_rounds("err_after", 0, 12);
  endtask

  task automatic test_ignored_start();
    start_expand(FIPS_KEY);
    while (edges < 19) step();
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    step();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL ignored_busy: got busy=%b want 1", busy);
    end
    wait_done("ignored");
    read_const("ignored_round12", 12, 128'he98ba06f448c773c8ecc720401002202);
    read_rounds("ignored_all", 0, 12);
  endtask

  task automatic test_reset_mid();
    start_expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    while (edges < 29) step();
    reset = 1'b1;
    start = 1'b1;
    key_in = {6{32'hdeadbeef}};
    step();
    reset = 1'b0;
    start = 1'b0;
    last_key = '0;
    model_ready = 1'b0;
    tests_run++;
    if ({busy, ready, done} !== 3'b000 || rd_key !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%b ready=%b done=%b key=%h want 0 0 0 0",
               busy, ready, done, rd_key);
    end
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wins: got busy=%b want 0", busy);
    end
    read_rounds("reset_mid_read", 12, 12);
    start_expand('0);
    wait_done("zero");
    read_rounds("zero_all", 0, 12);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 100; n++) begin
      start_expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      wait_done("random");
      read_rounds("random_rounds", 0, 12);
      if (n % 10 == 0) read_rounds("random_bad", 13, 14);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_errors();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
